// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg
//   Shared constants for the byte-RAM access controller: FSM state
//   encoding, access-size encoding and the default highest RAM address.
package ram_access_ctrl_pkg;

  // Highest valid byte address of the attached RAM (its MEM_LENGTH).
  localparam logic [15:0] MEM_LAST_DEFAULT = 16'd255;

  // Access size carried on req_word.
  localparam logic BYTE = 1'b0;
  localparam logic WORD = 1'b1;

  // Controller state encoding.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    FIN  = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage : ram_access_ctrl_pkg

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Initiator for a single-port byte RAM with one-cycle registered read
//   latency. Accepts byte / 16-bit loads and stores, splits 16-bit accesses
//   into two little-endian byte accesses and returns one response per
//   request.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
//   both 1. valid never depends on ready; once rsp_valid rises it and its
//   payload (rsp_rdata, rsp_err) hold until the rsp_ready handshake.
//   req_ready is high only in IDLE, so at most one request is outstanding.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write, req_word      1 = store / 1 = 16-bit access
//   req_addr, req_wdata      byte address (low byte of a word), store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       load data, out-of-range flag
//   mem_*                    RAM address/data_in/write_enable/read_enable,
//                            and data_out returned a cycle after read_enable
//   dbg_state                current FSM state
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter logic [15:0] MEM_LAST = MEM_LAST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_in,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [7:0]  mem_data_out,
  output logic [2:0]  dbg_state
);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        word_q, word_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [15:0] req_addr_hi;
  logic        req_oor;
  logic [15:0] addr_hi;

  // Range check: the high byte of a word wraps modulo 2^16 before it is
  // compared against the last valid address.
  always_comb begin
    req_addr_hi = req_addr + 16'd1;
    req_oor     = (req_addr > MEM_LAST) ||
                  ((req_word == WORD) && (req_addr_hi > MEM_LAST));
  end

  assign addr_hi = addr_q + 16'd1;

  // Next-state and request/response registers.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          word_d  = req_word;
          rdata_d = 16'd0;
          err_d   = req_oor;
          state_d = req_oor ? RESP : ACC0;
        end
      end
      ACC0: begin
        if (word_q == WORD)   state_d = ACC1;
        else if (write_q)     state_d = RESP;
        else                  state_d = FIN;
      end
      ACC1: begin
        // Low byte of a word load, read in ACC0, is on data_out now.
        if (!write_q) rdata_d[7:0] = mem_data_out;
        state_d = write_q ? RESP : FIN;
      end
      FIN: begin
        if (word_q == WORD) rdata_d[15:8] = mem_data_out;
        else                rdata_d[7:0]  = mem_data_out;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      rdata_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state only. They are forced to 0 while rst is
  // high so that a reset landing on an access edge never writes the RAM.
  always_comb begin
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_rdata        = 16'd0;
    rsp_err          = 1'b0;
    mem_address      = 16'd0;
    mem_data_in      = 8'd0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: req_ready = 1'b1;
        ACC0: begin
          mem_address = addr_q;
          if (write_q) begin
            mem_write_enable = 1'b1;
            mem_data_in      = wdata_q[7:0];
          end else begin
            mem_read_enable  = 1'b1;
          end
        end
        ACC1: begin
          mem_address = addr_hi;
          if (write_q) begin
            mem_write_enable = 1'b1;
            mem_data_in      = wdata_q[15:8];
          end else begin
            mem_read_enable  = 1'b1;
          end
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_rdata = rdata_q;
          rsp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule : ram_access_ctrl

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Initiator for the team's single-port byte RAM: accepts byte or 16-bit load/store requests over a valid/ready handshake and drives the RAM's `address`/`data_in`/`write_enable`/`read_enable` pins. It absorbs the RAM's one-cycle registered read latency and splits 16-bit accesses into two little-endian byte accesses. A single response is returned per request over a valid/ready handshake. Sits between the CPU datapath (load/store unit) and the `ram` instance.

## Interface
- `MEM_LAST`, 255: highest valid byte address; must match the RAM's `MEM_LENGTH`.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock, shared with the RAM.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_word`  in  1  1 = 16-bit access, 0 = byte.
- `req_addr`  in  16  byte address (low byte of a word).
- `req_wdata`  in  16  store data; only `[7:0]` is used for byte stores.
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  16  load data.
- `rsp_err`  out  1  request was out of range; no RAM access was made.
- `mem_address`  out  16  to RAM `address`.
- `mem_data_in`  out  8  to RAM `data_in`.
- `mem_write_enable`  out  1  to RAM `write_enable`.
- `mem_read_enable`  out  1  to RAM `read_enable`.
- `mem_data_out`  in  8  from RAM `data_out`; valid the cycle after `mem_read_enable`.

## Operation
- FSM states: IDLE, ACC0, ACC1, FIN, RESP.
- IDLE: `req_ready=1`. On handshake, register addr/wdata/write/word.
  - In range: go to ACC0.
  - Out of range: go to RESP with `rsp_err=1`. A request is out of range if `req_addr > MEM_LAST`, or if it is a word access and `req_addr+1` (16-bit wrap) `> MEM_LAST`.
- ACC0: `mem_address=addr`. A store drives `mem_write_enable=1` and `mem_data_in=wdata[7:0]`; a load drives `mem_read_enable=1`. Next state:
  - word access: ACC1;
  - byte load: FIN;
  - byte store: RESP.
- ACC1: `mem_address=addr+1`, mod 2^16. A store drives `mem_data_in=wdata[15:8]`. A load captures `mem_data_out` into `rdata[7:0]` and re-asserts `mem_read_enable`. Next state: load → FIN, store → RESP.
- FIN (load only): no enables asserted. Capture `mem_data_out` into `rdata[7:0]` for a byte load, or into `rdata[15:8]` for a word load. Next state: RESP.
- RESP: `rsp_valid=1`, with `rsp_rdata`/`rsp_err` stable. On `rsp_ready`, go to IDLE.
- Response data rules:
  - byte loads zero-extend: `rsp_rdata[15:8]=0`;
  - stores and errored requests return `rsp_rdata=0`;
  - `rsp_err=0` on every in-range request.
- `req_ready=0` in every state except IDLE, so there is never more than one outstanding request and no request/response overlap.
- Outside ACC0/ACC1, `mem_write_enable`, `mem_read_enable`, `mem_address` and `mem_data_in` are all 0. The memory-side outputs decode from state only, so the RAM sees them on the same edge that advances the FSM.

## Timing
- Reset values: state IDLE, `req_ready=0` while `rst=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, all `mem_*` outputs 0.
- Reset mid-operation abandons the request; no `mem_*` enable is asserted in the cycle after `rst` deasserts. A write already clocked into the RAM stays written.
- Cycles from accept edge to first `rsp_valid`:
  - byte store: 2;
  - word store: 3;
  - byte load: 3;
  - word load: 4;
  - out of range: 1.
- Peak throughput with `rsp_ready` tied high is one request per latency + 1 cycles, since IDLE occupies one cycle.
- `rsp_valid` stalls indefinitely while `rsp_ready=0`; its outputs hold.
- Address wrap: `0xFFFF+1 = 0x0000`. This is only reachable when `MEM_LAST=0xFFFF`.

## Structure
- A shared package or include holds the state encoding localparams (IDLE/ACC0/ACC1/FIN/RESP) and the access-size constants BYTE=0, WORD=1.
- Single flat module; no sub-module is needed. The range check is a few lines of combinational logic inside the block.

## Test plan
- Byte store 0xA5 to 0x0010, then byte load 0x0010:
  - store: `mem_write_enable` pulses 1 cycle with `mem_address=0x0010`, `mem_data_in=0xA5`; `rsp_valid` 2 cycles after accept;
  - load: `rsp_rdata=0x00A5`, `rsp_err=0`, `rsp_valid` 3 cycles after accept.
- Word store 0xBEEF to 0x0020, then word load 0x0020:
  - store: RAM[0x20]=0xEF, RAM[0x21]=0xBE;
  - load: `rsp_rdata=0xBEEF` at 4 cycles after accept.
- Word load at 0x00FF with `MEM_LAST=255` → `rsp_err=1`, `rsp_rdata=0`, no `mem_*` enable ever asserted, `rsp_valid` 1 cycle after accept.
- Hold `rsp_ready=0` for 5 cycles after a load of 0x3C → `rsp_valid` and `rsp_rdata=0x003C` held stable, `req_ready=0` throughout; IDLE is re-entered the cycle after `rsp_ready=1`.
- Assert `rst` during ACC1 of a word store → next cycle all outputs at reset values. RAM[addr] holds the new low byte; RAM[addr+1] is unchanged.
- Back-to-back requests with `req_valid` and `rsp_ready` held high → no second accept before the first response handshake; the accept pattern repeats every latency + 1 cycles.
